moving_average_inverter: RTL and testbench

- Inverse of the moving-average accumulator: consumes the full-precision N-sample moving sum and reconstructs the original sample stream exactly.
- Sits downstream of the averager's accumulator tap, before the feed sanity checker and replay logger.
- Used to verify averager integrity and recover raw ticks from a filtered channel.
- Recurrence: x[n] = y[n] - y[n-1] + x[n-N], with y[-1] = 0 and x[m<0] = 0; this zero history matches the averager's reset state.

---
 rtl/moving_average_pkg.sv | 12 +
 rtl/moving_average_inverter_if.sv | 27 ++
 rtl/sample_delay_line.sv | 29 ++
 rtl/moving_average_inverter.sv | 87 ++++++++
 tb/tb_moving_average_inverter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/moving_average_pkg.sv
// Shared sizing helpers for the moving-average accumulator and its inverter.
package moving_average_pkg;

  function automatic int unsigned acc_width(input int unsigned k, input int unsigned data_width);
    return data_width + k;
  endfunction

  function automatic int unsigned window_len(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/moving_average_inverter_if.sv
// Stream bus for the moving-average inverter: moving sums in, reconstructed samples out.
interface moving_average_inverter_if #(
  parameter int unsigned k          = 3,
  parameter int unsigned DATA_WIDTH = 16
);
  import moving_average_pkg::*;

  localparam int unsigned ACC_WIDTH = acc_width(k, DATA_WIDTH);

  logic                         in_valid;
  logic signed [ACC_WIDTH-1:0]  in_sum;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] d_out;
  logic                         primed;
  logic                         err;

  modport master (
    output in_valid, in_sum,
    input  out_valid, d_out, primed, err
  );

  modport slave (
    input  in_valid, in_sum,
    output out_valid, d_out, primed, err
  );

endinterface

// File: rtl/sample_delay_line.sv
// Fixed-depth shift register; q is the oldest entry. Synchronous clear, async reset.
module sample_delay_line #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (en) begin
      mem_q[0] <= d;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
    end
  end

  assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/moving_average_inverter.sv
// Recovers raw samples from an N-sample moving sum: x[n] = y[n] - y[n-1] + x[n-N].
module moving_average_inverter
  import moving_average_pkg::*;
#(
  parameter int unsigned k          = 3,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic                      clk,
  input logic                      reset,
  input logic                      clr,
  moving_average_inverter_if.slave bus
);

  localparam int unsigned ACC_WIDTH = acc_width(k, DATA_WIDTH);
  localparam int unsigned N         = window_len(k);
  localparam int unsigned CALC_W    = ACC_WIDTH + 2;
  localparam int unsigned CNT_W     = $clog2(N + 1);

  logic [ACC_WIDTH-1:0]       prev_sum_q;
  logic [CNT_W-1:0]           count_q;
  logic                       out_valid_q;
  logic [DATA_WIDTH-1:0]      d_out_q;
  logic                       primed_q;
  logic                       err_q;

  logic                       accept;
  logic [DATA_WIDTH-1:0]      oldest;
  logic [CALC_W-1:0]          diff;
  logic [CALC_W-1:0]          raw;
  logic [CALC_W-DATA_WIDTH:0] top_bits;
  logic                       ovf;

  always_comb begin
    accept   = bus.in_valid & ~clr;
    diff     = {{2{bus.in_sum[ACC_WIDTH-1]}}, bus.in_sum}
             - {{2{prev_sum_q[ACC_WIDTH-1]}}, prev_sum_q};
    raw      = diff + {{(CALC_W-DATA_WIDTH){oldest[DATA_WIDTH-1]}}, oldest};
    // Fits DATA_WIDTH signed iff every bit from the target sign bit upward agrees.
    top_bits = raw[CALC_W-1:DATA_WIDTH-1];
    ovf      = (|top_bits) & ~(&top_bits);
  end

  sample_delay_line #(
    .DEPTH (N),
    .WIDTH (DATA_WIDTH)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .en    (accept),
    .clr   (clr),
    .d     (raw[DATA_WIDTH-1:0]),
    .q     (oldest)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sum_q  <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      d_out_q     <= '0;
      primed_q    <= 1'b0;
      err_q       <= 1'b0;
    end else if (clr) begin
      // d_out is left alone: clr only flushes history and flags.
      prev_sum_q  <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      prev_sum_q  <= bus.in_sum;
      out_valid_q <= 1'b1;
      d_out_q     <= raw[DATA_WIDTH-1:0];
      if (count_q != CNT_W'(N)) count_q <= count_q + CNT_W'(1);
      if (count_q == CNT_W'(N - 1)) primed_q <= 1'b1;
      if (ovf) err_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d_out     = d_out_q;
  assign bus.primed    = primed_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_moving_average_inverter.sv
// Scoreboard bench for moving_average_inverter at k=3, DATA_WIDTH=16.
module tb_moving_average_inverter;

  localparam int unsigned K  = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = DW + K;

  logic clk;
  logic reset;
  logic clr;

  moving_average_inverter_if #(.k(K), .DATA_WIDTH(DW)) bus ();

  moving_average_inverter #(.k(K), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic signed [DW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int sum);
    bus.in_valid = v;
    bus.in_sum   = AW'(sum);
  endtask

  task automatic apply_reset();
    drive(1'b0, 0);
    clr   = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.d_out !== 16'sd0 || bus.primed !== 1'b0
        || bus.err !== 1'b0) begin
      $display("FAIL reset: ov=%b d_out=%0d primed=%b err=%b, want all 0",
               bus.out_valid, bus.d_out, bus.primed, bus.err);
      n_fail++;
    end
  endtask

  // Back-to-back stream; expected samples come from the scenario tables.
  task automatic test_stream(input string name, input int n, input int sums[12],
                             input int exps[12]);
    logic signed [DW-1:0] e;
    apply_reset();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, sums[i]);
      exp_q.push_back(DW'(exps[i]));
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL %s[%0d] out_valid: got %b want 1", name, i, bus.out_valid);
        n_fail++;
      end else begin
        e = exp_q.pop_front();
        if (bus.d_out !== e) begin
          $display("FAIL %s[%0d] d_out: got %0d want %0d", name, i, bus.d_out, e);
          n_fail++;
        end
      end
      n_tests++;
      if (bus.primed !== (i >= 7)) begin
        $display("FAIL %s[%0d] primed: got %b want %b", name, i, bus.primed, i >= 7);
        n_fail++;
      end
    end
    drive(1'b0, 0);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
      $display("FAIL %s end: ov=%b err=%b want 0/0", name, bus.out_valid, bus.err);
      n_fail++;
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    drive(1'b1, 40000);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.d_out !== -16'sd25536 || bus.err !== 1'b1) begin
      $display("FAIL ovf first: ov=%b d_out=%0d err=%b want 1/-25536/1",
               bus.out_valid, bus.d_out, bus.err);
      n_fail++;
    end
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.d_out !== 16'sd0 || bus.err !== 1'b1) begin
      $display("FAIL ovf second: ov=%b d_out=%0d err=%b want 1/0/1",
               bus.out_valid, bus.d_out, bus.err);
      n_fail++;
    end
    drive(1'b0, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (bus.err !== 1'b0 || bus.primed !== 1'b0 || bus.out_valid !== 1'b0) begin
      $display("FAIL ovf clr: err=%b primed=%b ov=%b want 0/0/0",
               bus.err, bus.primed, bus.out_valid);
      n_fail++;
    end
  endtask

  task automatic test_gaps();
    int highs = 0;
    apply_reset();
    drive(1'b1, 7);
    tick();
    highs += int'(bus.out_valid);
    n_tests++;
    if (bus.d_out !== 16'sd7) begin
      $display("FAIL gap first d_out: got %0d want 7", bus.d_out);
      n_fail++;
    end
    drive(1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      highs += int'(bus.out_valid);
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.d_out !== 16'sd7) begin
        $display("FAIL gap idle[%0d]: ov=%b d_out=%0d want 0/7", i, bus.out_valid, bus.d_out);
        n_fail++;
      end
    end
    drive(1'b1, 14);
    tick();
    highs += int'(bus.out_valid);
    n_tests++;
    if (bus.d_out !== 16'sd7) begin
      $display("FAIL gap second d_out: got %0d want 7", bus.d_out);
      n_fail++;
    end
    drive(1'b0, 0);
    tick();
    highs += int'(bus.out_valid);
    n_tests++;
    if (highs != 2) begin
      $display("FAIL gap valid count: got %0d want 2", highs);
      n_fail++;
    end
  endtask

  task automatic test_clr_with_valid();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 9 * i);
      tick();
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.d_out !== 16'sd9) begin
        $display("FAIL clrv acc[%0d]: ov=%b d_out=%0d want 1/9", i, bus.out_valid, bus.d_out);
        n_fail++;
      end
    end
    drive(1'b1, 45);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL clrv drop: out_valid got %b want 0", bus.out_valid);
      n_fail++;
    end
    drive(1'b1, 3);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.d_out !== 16'sd3 || bus.primed !== 1'b0) begin
      $display("FAIL clrv after: ov=%b d_out=%0d primed=%b want 1/3/0",
               bus.out_valid, bus.d_out, bus.primed);
      n_fail++;
    end
    drive(1'b0, 0);
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 40000);
      tick();
    end
    drive(1'b1, 40005);
    tick();
    n_tests++;
    if (bus.d_out !== -16'sd25531 || bus.primed !== 1'b1 || bus.err !== 1'b1) begin
      $display("FAIL arst setup: d_out=%0d primed=%b err=%b want -25531/1/1",
               bus.d_out, bus.primed, bus.err);
      n_fail++;
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.d_out !== 16'sd0 || bus.primed !== 1'b0
        || bus.err !== 1'b0) begin
      $display("FAIL arst immediate: ov=%b d_out=%0d primed=%b err=%b want all 0",
               bus.out_valid, bus.d_out, bus.primed, bus.err);
      n_fail++;
    end
    #1;
    reset = 1'b0;
    drive(1'b1, 6);
    tick();
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.d_out !== 16'sd6) begin
      $display("FAIL arst resume: ov=%b d_out=%0d want 1/6", bus.out_valid, bus.d_out);
      n_fail++;
    end
    drive(1'b0, 0);
    tick();
  endtask

  int c_sums[12] = '{5, 10, 15, 20, 25, 30, 35, 40, 40, 40, 40, 40};
  int c_exps[12] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
  int i_sums[12] = '{100, 100, 100, 100, 100, 100, 100, 100, 0, 0, 0, 0};
  int i_exps[12] = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int n_sums[12] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, 0, 0, 0, 0};
  int n_exps[12] = '{-32768, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    reset        = 1'b1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sum   = '0;
    #3;
    test_reset();
    reset = 1'b0;
    tick();
    test_stream("constant", 12, c_sums, c_exps);
    test_stream("impulse", 12, i_sums, i_exps);
    test_stream("negext", 9, n_sums, n_exps);
    test_overflow();
    test_gaps();
    test_clr_with_valid();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
